// File: rtl/serial_add_if.sv
// Handshake and data bundle for the bit-serial adder.
// The master drives the request and operands; the slave returns status and result.
interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  modport master (
    output start, a, b, ci,
    input  busy, done, s, co
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, s, co
  );
endinterface

// File: rtl/serial_add.sv
// Bit-serial ripple adder: one full-add cell, a registered carry,
// one bit resolved per clock LSB-first, WIDTH-bit sum plus carry-out.
//
// state  | meaning
// -------+--------------------------------------------
// S_IDLE | waiting for start
// S_RUN  | one bit resolved per cycle
// S_DONE | result published, lasts one cycle
module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sum_bit;
  logic             carry_nxt;

  // Register bank: everything, including the published result, clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, datapath and status: the single full-add cell lives here.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    co_d      = co_q;

    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new request exactly like IDLE so back-to-back
        // operations cost only the single publish cycle.
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.ci;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // start is deliberately not looked at here.
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          s_d     = {sum_bit, res_q[WIDTH-1:1]};
          co_d    = carry_nxt;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;

endmodule

// File: doc/serial_add.md
# serial_add

Bit-serial ripple adder: accepts two WIDTH-bit unsigned operands plus a carry-in, resolves one bit per clock LSB-first through a single full-add cell and a registered carry, and returns the WIDTH-bit sum and carry-out. It is the additive counterpart of our full/half subtractor cells and the area-minimal adder for arithmetic blocks where latency is cheap. It is built around one full-add equation (s = a^b^c, c' = ab | c(a^b)), with the carry held in a flip-flop between bits.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; sampled only on an accepted start.
- b  input  WIDTH  operand B; sampled only on an accepted start.
- ci  input  1  carry-in; sampled only on an accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; s and co are valid from this cycle.
- s  output  WIDTH  sum, modulo 2^WIDTH.
- co  output  1  carry out of bit WIDTH-1.

## Operation
- Reset is asynchronous, active-high. While rst=1, force:
  - outputs busy=0, done=0, s=0, co=0;
  - internal shift registers, carry flip-flop and bit counter to 0;
  - state to IDLE.
- A reset asserted mid-operation discards the addition in progress; no done pulse follows.
- States:
  - IDLE: waiting for start.
  - RUN: one bit resolved per cycle.
  - DONE: result published; lasts one cycle.
- IDLE, start=1: latch a, b and ci into operand shift registers and the carry flip-flop, clear the bit counter, go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, every edge:
  - sum bit = a[0]^b[0]^carry; shift it into the MSB of the result register.
  - Update carry with the full-add carry.
  - Shift both operand registers right by one; increment the counter.
- RUN, on the edge where the counter equals WIDTH-1:
  - copy the completed result register to s and the new carry to co;
  - go to DONE.
- DONE: if start=1, accept the new operands exactly as from IDLE and go to RUN; otherwise go to IDLE.
- start while in RUN is ignored. The operation is not restarted and the operands are not re-sampled.
- a, b and ci may change freely while busy=1; only the values sampled with start matter.
- s and co hold their last values until the next completion or reset; they are not cleared by start.
- Arithmetic: {co, s} = a + b + ci, computed exactly (WIDTH+1 bits); no signed interpretation.
- Bit counter width: clog2(WIDTH).

## Timing
- Edge 0 samples start=1 (state IDLE or DONE); busy=1 from edge 0.
- Bits 0..WIDTH-1 are resolved on edges 1..WIDTH.
- At edge WIDTH: s and co update, done=1 and busy=0.
- Latency: start to done is WIDTH cycles. done is high for exactly one cycle.
- Back-to-back: start held high in the done cycle makes busy=1 again at the next edge, giving a throughput of one result per WIDTH+1 cycles.
- busy and done are never high in the same cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
All scenarios use WIDTH=8.
- Reset: rst pulsed asynchronously between clock edges -> busy, done, s and co go to 0 immediately, without waiting for a clock edge.
- Basic sum: a=0x35, b=0x4A, ci=0, pulse start -> done exactly 8 cycles after the start edge; s=0x7F, co=0; busy high for 8 cycles.
- Wrap-around: a=0xFF, b=0x01, ci=0 -> s=0x00, co=1. a=0xFF, b=0xFF, ci=1 -> s=0xFF, co=1.
- Ignored start and operand change: start pulsed and a, b changed 3 cycles into an addition of 0x10+0x20 -> done still 8 cycles after the first start; s=0x30; no second operation begins.
- Back-to-back: start held high through the done cycle of 0x01+0x02, with a and b switched to 0x80+0x80 -> first done gives s=0x03, co=0; second done exactly 9 cycles later gives s=0x00, co=1.
- Reset mid-run: rst asserted 4 cycles into 0x55+0xAA, then released, then 0x01+0x01 started -> no done for the aborted operation; the later operation gives s=0x02, co=0.
